logger_fifo_param: RTL and testbench
====================================

// Module: logger_fifo_param
// PURPOSE
//  Parametrised synchronous FIFO for the data logger; successor to the fixed 32-bit logger FIFO.
//  Adds configurable width/depth, occupancy count, almost-full/almost-empty thresholds,
//  sticky overflow/underflow error flags and a registered read-valid strobe.
//  Sits between the capture front-end (writer) and the UART transmit path (reader).
// PARAMETERS
//  DATA_W     32  data word width in bits (>=1)
//  DEPTH      16  number of entries; power of two, >=4
//  AF_MARGIN  2   almost_full asserts when count >= DEPTH-AF_MARGIN (0 < AF_MARGIN < DEPTH)
//  AE_MARGIN  2   almost_empty asserts when count <= AE_MARGIN (AE_MARGIN < DEPTH)
//  TS_W       16  timestamp width; used only with LOGGER_TIMESTAMP_EN
// PORTS
//  clk           in   1                    single clock, all logic on rising edge
//  reset         in   1                    synchronous, active-high
//  write_enable  in   1                    write request
//  write_data    in   DATA_W               write word
//  read_enable   in   1                    read request
//  read_data     out  DATA_W               read word, registered
//  read_valid    out  1                    read_data updated this cycle
//  full          out  1                    count == DEPTH
//  empty         out  1                    count == 0
//  almost_full   out  1                    threshold flag
//  almost_empty  out  1                    threshold flag
//  count         out  $clog2(DEPTH+1)      current occupancy
//  overflow      out  1                    sticky: write attempted while full and not accepted
//  underflow     out  1                    sticky: read attempted while empty
//  clear_errors  in   1                    clears overflow/underflow
//  read_ts       out  TS_W                 timestamp of read word (LOGGER_TIMESTAMP_EN only)
// BEHAVIOUR
//  - Reset (sync, dominates all inputs): wr/rd pointers=0, count=0, read_data=0, read_valid=0,
//    full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0, read_ts=0,
//    timestamp counter=0. Storage array contents not cleared. Reset mid-burst discards all data.
//  - Pointers are $clog2(DEPTH) bits; wrap DEPTH-1 -> 0 naturally.
//  - wr_ok = write_enable & (~full | rd_ok); rd_ok = read_enable & ~empty.
//  - Write: on wr_ok, mem[wr_ptr] <= write_data, wr_ptr++.
//  - Read latency 1: on rd_ok, read_data <= mem[rd_ptr], rd_ptr++, read_valid=1 next cycle;
//    otherwise read_valid=0 and read_data holds its last value.
//  - count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
//  - full/empty/almost_* are derived from registered count; they reflect an accepted
//    operation the cycle after the edge that performed it.
//  - Full + read + write same cycle: both accepted, count stays DEPTH, no overflow.
//  - Empty + read + write same cycle: write accepted, read rejected, underflow set, count=1.
//  - overflow set on write_enable & full & ~rd_ok; underflow set on read_enable & empty.
//    Both sticky until clear_errors or reset; a set event in the same cycle as clear_errors wins.
//  - Rejected operations change no pointer, count or data.
// CONFIGURATION
//  - LOGGER_TIMESTAMP_EN defined: free-running TS_W counter (wraps), +1 every cycle after reset;
//    each accepted write stores the counter value alongside the data; read_ts updates with
//    read_data (same latency, same hold rule). Port read_ts present.
//  - Not defined: no counter, no timestamp storage, read_ts port absent.
// TESTING (DATA_W=32, DEPTH=16, AF_MARGIN=2, AE_MARGIN=2)
//  - Reset then idle -> empty=1, almost_empty=1, full=0, count=0, read_valid=0, flags=0.
//  - Write 16 words 0x1000+i, then write 0xDEAD -> full=1 after 16th, almost_full from count=14,
//    overflow=1, count=16; 16 reads return 0x1000..0x100F in order, read_valid 1 cycle after each.
//  - Read on empty FIFO -> underflow=1, read_valid=0, count=0; clear_errors pulse -> underflow=0.
//  - Full FIFO, write 0xBEEF + read together -> head word returned, count=16, overflow=0;
//    0xBEEF emerges as 16th subsequent read (pointer wrap verified).
//  - 5 writes, assert reset for 1 cycle mid-stream with write_enable high -> count=0, empty=1,
//    next write/read returns the new word, not pre-reset data.
//  - With LOGGER_TIMESTAMP_EN: writes at cycles 3 and 7 after reset -> read_ts = 3 then 7.

Source files
------------

// File: rtl/logger_fifo_param.sv
// rtl/logger_fifo_param.sv - parametrised synchronous logger FIFO with flags and sticky errors
//
// Optional feature macro: LOGGER_TIMESTAMP_EN (timestamp capture per word, read_ts port)
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   write_enable/data   writer side (capture front-end)
//   read_enable         reader request (UART transmit path)
//   read_data/valid     registered read word and its one-cycle strobe
//   full, empty         occupancy extremes
//   almost_full/empty   threshold flags from AF_MARGIN / AE_MARGIN
//   count               current occupancy, 0..DEPTH
//   overflow/underflow  sticky error flags, cleared by clear_errors
//   read_ts             timestamp of the read word (LOGGER_TIMESTAMP_EN only)
module logger_fifo_param #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int AF_MARGIN = 2,
   parameter int AE_MARGIN = 2,
   parameter int TS_W      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_enable,
   input  logic [DATA_W-1:0]          write_data,
   input  logic                       read_enable,
   output logic [DATA_W-1:0]          read_data,
   output logic                       read_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow,
`ifdef LOGGER_TIMESTAMP_EN
   output logic [TS_W-1:0]            read_ts,
`endif
   input  logic                       clear_errors
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);
   localparam logic [CNT_W-1:0] AE_LEVEL   = CNT_W'(AE_MARGIN);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              wr_ok;
   logic              rd_ok;

   // Flags follow the registered count, so they lag an accepted operation by one edge.
   assign full         = (count == FULL_LEVEL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_LEVEL);
   assign almost_empty = (count <= AE_LEVEL);

   // A write into a full FIFO is still accepted when a read frees the head slot this cycle.
   assign rd_ok = read_enable & ~empty;
   assign wr_ok = write_enable & (~full | rd_ok);

   // Storage is deliberately not reset; stale contents are unreachable once pointers reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem[wr_ptr] <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         read_data  <= '0;
         read_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         read_valid <= rd_ok;
         if (rd_ok) begin
            read_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
         end
         if (wr_ok && !rd_ok) begin
            count <= count + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            count <= count - 1'b1;
         end
         // Set events take priority over a simultaneous clear.
         if (write_enable && full && !rd_ok) begin
            overflow <= 1'b1;
         end else if (clear_errors) begin
            overflow <= 1'b0;
         end
         if (read_enable && empty) begin
            underflow <= 1'b1;
         end else if (clear_errors) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef LOGGER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] ts_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         ts_mem[wr_ptr] <= ts_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_cnt  <= '0;
         read_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (rd_ok) begin
            read_ts <= ts_mem[rd_ptr];
         end
      end
   end
`endif

endmodule

// File: tb/tb_logger_fifo_param.sv
// tb/tb_logger_fifo_param.sv - scoreboard bench for logger_fifo_param
module tb_logger_fifo_param;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int AF_M   = 2;
   localparam int AE_M   = 2;
   localparam int TS_W   = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              write_enable = 1'b0;
   logic [DATA_W-1:0] write_data = '0;
   logic              read_enable = 1'b0;
   logic              clear_errors = 1'b0;
   logic [DATA_W-1:0] read_data;
   logic              read_valid;
   logic              full, empty, almost_full, almost_empty;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic              overflow, underflow;
`ifdef LOGGER_TIMESTAMP_EN
   logic [TS_W-1:0]   read_ts;
`endif

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] model_q[$];
   logic [TS_W-1:0]   model_ts_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [TS_W-1:0]   exp_ts_q[$];
   logic              model_ovf = 1'b0;
   logic              model_udf = 1'b0;
   logic [TS_W-1:0]   model_ts = '0;
   logic              exp_rv = 1'b0;
   logic              mon_en = 1'b0;
   logic [DATA_W-1:0] last_rd = '0;
   logic [TS_W-1:0]   last_ts = '0;

   logger_fifo_param #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_M), .AE_MARGIN(AE_M), .TS_W(TS_W)
   ) dut (
      .clk(clk), .reset(reset),
      .write_enable(write_enable), .write_data(write_data),
      .read_enable(read_enable),
      .read_data(read_data), .read_valid(read_valid),
      .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow),
`ifdef LOGGER_TIMESTAMP_EN
      .read_ts(read_ts),
`endif
      .clear_errors(clear_errors)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the queue model, then compare registered state.
   task automatic step(input logic rst, input logic we, input logic [DATA_W-1:0] wd,
                       input logic re, input logic ce);
      int  n;
      bit  rd_acc, wr_acc;
      @(negedge clk);
      reset = rst; write_enable = we; write_data = wd;
      read_enable = re; clear_errors = ce;
      n = model_q.size();
      rd_acc = 1'b0;
      if (rst) begin
         model_q.delete();
         model_ts_q.delete();
         model_ovf = 1'b0;
         model_udf = 1'b0;
      end else begin
         rd_acc = re && (n > 0);
         wr_acc = we && ((n < DEPTH) || rd_acc);
         if (rd_acc) begin
            exp_q.push_back(model_q.pop_front());
            exp_ts_q.push_back(model_ts_q.pop_front());
         end
         if (wr_acc) begin
            model_q.push_back(wd);
            model_ts_q.push_back(model_ts);
         end
         if (we && (n == DEPTH) && !rd_acc) model_ovf = 1'b1;
         else if (ce) model_ovf = 1'b0;
         if (re && (n == 0)) model_udf = 1'b1;
         else if (ce) model_udf = 1'b0;
      end
      @(posedge clk);
      #1;
      model_ts = rst ? '0 : model_ts + 1'b1;
      exp_rv = rd_acc;
      if (rst) begin
         last_rd = '0;
         last_ts = '0;
      end
      n = model_q.size();
      chk("count", count, n);
      chk("full", full, n == DEPTH);
      chk("empty", empty, n == 0);
      chk("almost_full", almost_full, n >= DEPTH - AF_M);
      chk("almost_empty", almost_empty, n <= AE_M);
      chk("overflow", overflow, model_ovf);
      chk("underflow", underflow, model_udf);
   endtask

   // Monitor: consumes expected read words whenever the DUT strobes read_valid.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("read_valid", read_valid, exp_rv);
         if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_read", 1, 0);
            end else begin
               last_rd = exp_q.pop_front();
               last_ts = exp_ts_q.pop_front();
               chk("read_data", read_data, last_rd);
`ifdef LOGGER_TIMESTAMP_EN
               chk("read_ts", read_ts, last_ts);
`endif
            end
         end else begin
            chk("read_data_hold", read_data, last_rd);
`ifdef LOGGER_TIMESTAMP_EN
            chk("read_ts_hold", read_ts, last_ts);
`endif
         end
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      mon_en = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Fill to full, then overflow attempt, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h1000 + i, 0, 0);
      step(0, 1, 32'hDEAD, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      // Underflow then clear.
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);

      // Full plus simultaneous read and write: wrap check.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h2000 + i, 0, 0);
      step(0, 1, 32'hBEEF, 1, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      // Empty plus simultaneous read and write.
      step(0, 1, 32'h3333, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);

      // Reset mid-burst with write_enable high.
      for (int i = 0; i < 5; i++) step(0, 1, 32'h4000 + i, 0, 0);
      step(1, 1, 32'h4444, 0, 0);
      step(0, 1, 32'h5555, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      // Timestamp capture at cycles 3 and 7 after reset.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 32'h7003, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 32'h7007, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      // Random traffic with phases biased toward filling and draining.
      for (int i = 0; i < 2000; i++) begin
         int wp, rp;
         wp = ((i / 100) % 2 == 0) ? 75 : 30;
         rp = ((i / 100) % 2 == 0) ? 30 : 75;
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < wp),
              $urandom,
              ($urandom_range(0, 99) < rp),
              ($urandom_range(0, 19) == 0));
      end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
